alu_ctrl_muldiv: RTL and testbench

- Next-generation EX-stage ALU controller for the pipelined MIPS core.
- Keeps the ALUOp/funct → ALUCtrl decode and is parametrised in width.
- Adds an iterative multiply/divide unit with HI/LO registers, a pipeline stall handshake, and MFHI/MFLO/MTHI/MTLO support.
- The multiply previously decoded into the ALU (funct 24 → 8) moves into this unit.

---
 rtl/alu_ctrl_muldiv.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_ctrl_muldiv.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_muldiv.sv
// EX-stage ALU controller with an iterative multiply/divide unit.
//
// Decodes ALUOp/funct into the ALU operation select and hosts the HI/LO
// registers together with a one-bit-per-cycle multiplier/divider.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous, active-high reset
//   valid_i      EX-stage instruction is valid
//   funct_i      R-type funct field
//   ALUOp_i      opcode class from the decoder
//   src1_i       rs operand (dividend / multiplicand / MT source)
//   src2_i       rt operand (divisor / multiplier)
//   ALUCtrl_o    ALU operation select (combinational)
//   md_sel_o     EX result comes from md_result_o instead of the ALU
//   md_result_o  HI (MFHI) or LO (MFLO), zero otherwise
//   stall_o      freeze IF/ID/EX while the mul/div unit is working
//   hi_o, lo_o   current HI/LO register contents
module alu_ctrl_muldiv #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ALUOP_W = 4,
  parameter int unsigned CTRL_W  = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [5:0]         funct_i,
  input  logic [ALUOP_W-1:0] ALUOp_i,
  input  logic [DATA_W-1:0]  src1_i,
  input  logic [DATA_W-1:0]  src2_i,
  output logic [CTRL_W-1:0]  ALUCtrl_o,
  output logic               md_sel_o,
  output logic [DATA_W-1:0]  md_result_o,
  output logic               stall_o,
  output logic [DATA_W-1:0]  hi_o,
  output logic [DATA_W-1:0]  lo_o
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [2*DATA_W-1:0]     prod_q, prod_d;   // mul: {acc, multiplier}; div: {rem, quot}
  logic [DATA_W-1:0]       mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic                    is_div_q, is_div_d;
  logic                    neg_q, neg_d;     // negate product / quotient
  logic                    neg_rem_q, neg_rem_d;
  logic                    divz_q, divz_d;
  logic [DATA_W-1:0]       hi_q, hi_d;
  logic [DATA_W-1:0]       lo_q, lo_d;

  // ALU control decode
  always_comb begin
    ALUCtrl_o = '0;
    case (ALUOp_i)
      ALUOP_W'(0): begin
        case (funct_i)
          6'd32:   ALUCtrl_o = CTRL_W'(2);
          6'd34:   ALUCtrl_o = CTRL_W'(6);
          6'd36:   ALUCtrl_o = CTRL_W'(0);
          6'd37:   ALUCtrl_o = CTRL_W'(1);
          6'd42:   ALUCtrl_o = CTRL_W'(7);
          default: ALUCtrl_o = '0;
        endcase
      end
      ALUOP_W'(1): ALUCtrl_o = CTRL_W'(2);
      ALUOP_W'(2): ALUCtrl_o = CTRL_W'(7);
      ALUOP_W'(3): ALUCtrl_o = CTRL_W'(13);
      ALUOP_W'(4): ALUCtrl_o = CTRL_W'(2);
      ALUOP_W'(5): ALUCtrl_o = CTRL_W'(2);
      ALUOP_W'(6): ALUCtrl_o = CTRL_W'(9);
      ALUOP_W'(7): ALUCtrl_o = CTRL_W'(10);
      ALUOP_W'(8): ALUCtrl_o = CTRL_W'(11);
      default:     ALUCtrl_o = '0;
    endcase
  end

  // Instruction qualifiers
  logic rtype, md_op, mdstart, signed_op, div_op;
  logic mt_hi, mt_lo;

  assign rtype     = valid_i && (ALUOp_i == '0);
  assign md_op     = (funct_i == 6'd24) || (funct_i == 6'd25) ||
                     (funct_i == 6'd26) || (funct_i == 6'd27);
  assign mdstart   = (state_q == StIdle) && rtype && md_op;
  assign signed_op = ~funct_i[0];
  assign div_op    = funct_i[1];

  assign stall_o = mdstart || (state_q == StBusy);
  assign mt_hi   = rtype && !stall_o && (funct_i == 6'd17);
  assign mt_lo   = rtype && !stall_o && (funct_i == 6'd19);

  always_comb begin
    md_sel_o    = 1'b0;
    md_result_o = '0;
    if (rtype && (funct_i == 6'd16)) begin
      md_sel_o    = 1'b1;
      md_result_o = hi_q;
    end else if (rtype && (funct_i == 6'd18)) begin
      md_sel_o    = 1'b1;
      md_result_o = lo_q;
    end
  end

  // Operand magnitudes for signed ops
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  assign a_neg = signed_op && src1_i[DATA_W-1];
  assign b_neg = signed_op && src2_i[DATA_W-1];
  assign a_mag = a_neg ? (~src1_i + DATA_W'(1)) : src1_i;
  assign b_mag = b_neg ? (~src2_i + DATA_W'(1)) : src2_i;

  // One shift-add multiply step
  logic [DATA_W:0]       mul_sum;
  logic [2*DATA_W-1:0]   mul_step;

  assign mul_sum  = {1'b0, prod_q[2*DATA_W-1:DATA_W]} +
                    {1'b0, (prod_q[0] ? mcand_q : {DATA_W{1'b0}})};
  assign mul_step = {mul_sum, prod_q[DATA_W-1:1]};

  // One restoring divide step; a zero divisor always "succeeds", giving all-ones quotient
  logic [DATA_W:0]       div_shift, div_diff;
  logic                  div_ok;
  logic [2*DATA_W-1:0]   div_step;

  assign div_shift = {prod_q[2*DATA_W-1:DATA_W], prod_q[DATA_W-1]};
  assign div_ok    = div_shift >= {1'b0, mcand_q};
  assign div_diff  = div_shift - {1'b0, mcand_q};
  assign div_step  = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                      prod_q[DATA_W-2:0], div_ok};

  // Sign fix-up of final results
  logic [2*DATA_W-1:0] mul_res;
  logic [DATA_W-1:0]   quot, rem;

  assign mul_res = neg_q ? (~prod_q + (2*DATA_W)'(1)) : prod_q;
  assign quot    = neg_q ? (~prod_q[DATA_W-1:0] + DATA_W'(1)) : prod_q[DATA_W-1:0];
  assign rem     = neg_rem_q ? (~prod_q[2*DATA_W-1:DATA_W] + DATA_W'(1))
                             : prod_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    divz_d    = divz_q;
    hi_d      = mt_hi ? src1_i : hi_q;
    lo_d      = mt_lo ? src1_i : lo_q;

    case (state_q)
      StIdle: begin
        if (mdstart) begin
          state_d   = StBusy;
          cnt_d     = CntW'(DATA_W);
          is_div_d  = div_op;
          neg_d     = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          divz_d    = div_op && (src2_i == '0);
          if (div_op) begin
            mcand_d = b_mag;
            prod_d  = {{DATA_W{1'b0}}, a_mag};
          end else begin
            mcand_d = a_mag;
            prod_d  = {{DATA_W{1'b0}}, b_mag};
          end
        end
      end
      StBusy: begin
        prod_d = is_div_q ? div_step : mul_step;
        cnt_d  = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (is_div_q) begin
          lo_d = divz_q ? {DATA_W{1'b1}} : quot;
          hi_d = rem;
        end else begin
          lo_d = mul_res[DATA_W-1:0];
          hi_d = mul_res[2*DATA_W-1:DATA_W];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      prod_q    <= '0;
      mcand_q   <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      divz_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      divz_q    <= divz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// Directed self-checking bench for alu_ctrl_muldiv (DATA_W = 32).
// Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
module tb_alu_ctrl_muldiv;

  logic        clk;
  logic        rst;
  logic        valid;
  logic [5:0]  funct;
  logic [3:0]  aluop;
  logic [31:0] src1, src2;
  logic [3:0]  alu_ctrl;
  logic        md_sel;
  logic [31:0] md_result;
  logic        stall;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  alu_ctrl_muldiv #(
    .DATA_W (32),
    .ALUOP_W(4),
    .CTRL_W (4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid),
    .funct_i    (funct),
    .ALUOp_i    (aluop),
    .src1_i     (src1),
    .src2_i     (src2),
    .ALUCtrl_o  (alu_ctrl),
    .md_sel_o   (md_sel),
    .md_result_o(md_result),
    .stall_o    (stall),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Table of expected ALU control values
  function automatic logic [3:0] exp_ctrl(input logic [3:0] op, input logic [5:0] fn);
    case (op)
      4'd0: begin
        case (fn)
          6'd32:   return 4'd2;
          6'd34:   return 4'd6;
          6'd36:   return 4'd0;
          6'd37:   return 4'd1;
          6'd42:   return 4'd7;
          default: return 4'd0;
        endcase
      end
      4'd1, 4'd4, 4'd5: return 4'd2;
      4'd2:    return 4'd7;
      4'd3:    return 4'd13;
      4'd6:    return 4'd9;
      4'd7:    return 4'd10;
      4'd8:    return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  task automatic idle_inputs();
    valid = 1'b0;
    aluop = 4'd0;
    funct = 6'd0;
    src1  = '0;
    src2  = '0;
  endtask

  // Issue a mul/div, count stall cycles, then check HI/LO
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int n;
    @(posedge clk); #1;
    valid = 1'b1; aluop = 4'd0; funct = fn; src1 = a; src2 = b;
    n = 0;
    @(negedge clk);
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " stall_cycles"}, 64'(n), 64'd33);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check({tag, " hi"}, 64'(hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(lo), 64'(exp_lo));
  endtask

  logic [5:0] sweep_fn [7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd24, 6'd63};

  initial begin
    int n;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset stall", 64'(stall), 64'd0);
    check("reset md_sel", 64'(md_sel), 64'd0);
    check("reset md_result", 64'(md_result), 64'd0);
    check("reset hi", 64'(hi), 64'd0);
    check("reset lo", 64'(lo), 64'd0);

    // Decode sweep with valid low: no start may occur
    for (int op = 0; op < 16; op++) begin
      for (int f = 0; f < 7; f++) begin
        aluop = 4'(op);
        funct = sweep_fn[f];
        #1;
        check($sformatf("decode op%0d fn%0d", op, sweep_fn[f]), 64'(alu_ctrl),
              64'(exp_ctrl(4'(op), sweep_fn[f])));
      end
    end
    @(negedge clk);
    check("no start when invalid", 64'(stall), 64'd0);
    idle_inputs();

    run_md("MULT 7*-3",  6'd24, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_md("MULTU 7*fffffffd", 6'd25, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 32'hFFFF_FFEB);
    run_md("DIVU 100/7", 6'd27, 32'd100, 32'd7, 32'd2, 32'd14);
    run_md("DIV -7/2",   6'd26, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("DIV min/-1", 6'd26, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_md("DIVU 5/0",   6'd27, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // MTHI then MFHI
    @(posedge clk); #1;
    valid = 1'b1; aluop = 4'd0; funct = 6'd17; src1 = 32'h1234;
    @(posedge clk); #1;
    funct = 6'd16; src1 = 32'h0;
    @(negedge clk);
    check("MFHI md_sel", 64'(md_sel), 64'd1);
    check("MFHI md_result", 64'(md_result), 64'h1234);
    funct = 6'd18;
    #1;
    check("MFLO md_result", 64'(md_result), 64'hFFFF_FFFF);
    valid = 1'b0;
    #1;
    check("MFLO invalid md_sel", 64'(md_sel), 64'd0);
    check("MFLO invalid md_result", 64'(md_result), 64'd0);

    // MTLO while stalled must be ignored
    @(posedge clk); #1;
    valid = 1'b1; aluop = 4'd0; funct = 6'd25; src1 = 32'd2; src2 = 32'd3;
    @(posedge clk); #1;
    funct = 6'd19; src1 = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("MTLO during stall", 64'(lo), 64'hFFFF_FFFF);
    #1;
    funct = 6'd25; src1 = 32'd2;
    n = 0;
    while (stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("MULTU 2*3 finished", 64'(n < 100), 64'd1);
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    check("MULTU 2*3 hi", 64'(hi), 64'd0);
    check("MULTU 2*3 lo", 64'(lo), 64'd6);

    // Reset in BUSY cycle 10 of a MULT (HI/LO nonzero beforehand)
    @(posedge clk); #1;
    valid = 1'b1; funct = 6'd17; src1 = 32'h55;
    @(posedge clk); #1;
    funct = 6'd24; src1 = 32'd7; src2 = 32'hFFFF_FFFD;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort stall", 64'(stall), 64'd0);
    check("abort hi", 64'(hi), 64'd0);
    check("abort lo", 64'(lo), 64'd0);

    run_md("DIVU 9/3", 6'd27, 32'd9, 32'd3, 32'd0, 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
